// File: rtl/wb_pipe_stage_pkg.sv
// ============================================================================
//  Module      : wb_pipe_stage_pkg
//  Description : Shared pipeline definitions for the MEM->WB stage: default
//                field widths and the packed writeback entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pipe_stage_pkg;

  localparam int WB_PC_W   = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_DEST_W = 5;

  // One in-flight writeback entry at the default core widths.
  typedef struct packed {
    logic [WB_PC_W-1:0]   pc;
    logic [WB_DATA_W-1:0] result;
    logic                 wb_en;
    logic                 mem_read;
    logic [WB_DEST_W-1:0] dest;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

`default_nettype wire

// File: rtl/wb_pipe_stage_pipe_entry_reg.sv
// ============================================================================
//  Module      : pipe_entry_reg
//  Description : Single pipeline entry register with load enable and
//                asynchronous clear. Used for both the main and skid slots.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_entry_reg
  import wb_pipe_stage_pkg::*;
#(
  parameter int W = WB_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the entry when loaded; clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_pipe_stage.sv
// ============================================================================
//  Module      : wb_pipe_stage
//  Description : MEM->WB pipeline stage with valid/ready handshake, optional
//                one-entry skid buffer, flush, control-bit qualification and
//                a saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int PC_W   = WB_PC_W,
  parameter int DEST_W = WB_DEST_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_wb_en,
  input  logic              in_mem_read,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_result,
  output logic              out_wb_en,
  output logic              out_mem_read,
  output logic [DEST_W-1:0] out_dest,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Same field order as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;
    logic              wb_en;
    logic              mem_read;
    logic [DEST_W-1:0] dest;
  } entry_t;

  localparam int             ENTRY_W = $bits(entry_t);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t in_entry;
  entry_t main_d;
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   main_valid_nxt;
  logic   skid_valid_nxt;
  logic   main_load;
  logic   skid_load;
  logic   accept;
  logic   drain;

  assign in_entry = '{pc: in_pc, result: in_result, wb_en: in_wb_en,
                      mem_read: in_mem_read, dest: in_dest};

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_q)
      );
      // Ready depends only on registered state: no out_ready->in_ready path.
      assign in_ready = !skid_valid;
    end else begin : g_no_skid
      assign skid_q   = '0;
      // Single slot: a same-cycle drain frees the slot for the new entry.
      assign in_ready = !main_valid | out_ready;
    end
  endgenerate

  // Occupancy transitions and slot load enables; flush overrides everything.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_d         = in_entry;

    if (SKID != 0) begin
      if (!main_valid) begin
        if (accept) begin
          main_load      = 1'b1;
          main_valid_nxt = 1'b1;
        end
      end else if (skid_valid) begin
        // Full: skid cannot accept, so only a drain moves things along.
        if (drain) begin
          main_load      = 1'b1;
          main_d         = skid_q;
          skid_valid_nxt = 1'b0;
        end
      end else begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load      = 1'b1;
          skid_valid_nxt = 1'b1;
        end else if (drain) begin
          main_valid_nxt = 1'b0;
        end
      end
    end else begin
      if (accept) begin
        main_load      = 1'b1;
        main_valid_nxt = 1'b1;
      end else if (drain) begin
        main_valid_nxt = 1'b0;
      end
    end

    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
      main_load      = 1'b0;
      skid_load      = 1'b0;
    end
  end

  // Slot valid flags; reset drops all entries without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
    end
  end

  // Saturating count of cycles where a valid output was back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid    = main_valid;
  assign out_pc       = main_q.pc;
  assign out_result   = main_q.result;
  assign out_dest     = main_q.dest;
  assign out_wb_en    = main_q.wb_en & main_valid;
  assign out_mem_read = main_q.mem_read & main_valid;

endmodule

`default_nettype wire

// File: tb/tb_wb_pipe_stage.sv
// ============================================================================
//  Module      : tb_wb_pipe_stage
//  Description : Self-checking bench for wb_pipe_stage. Drives one SKID=0 and
//                one SKID=1 instance with the same stimulus and checks both
//                against a queue model every cycle plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_pipe_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        wb;
    logic        mr;
    logic [4:0]  dest;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_result = '0;
  logic        in_wb_en = 1'b0;
  logic        in_mem_read = 1'b0;
  logic [4:0]  in_dest = '0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        rdy  [2];
  logic        ov   [2];
  logic [31:0] opc  [2];
  logic [31:0] ores [2];
  logic        owb  [2];
  logic        omr  [2];
  logic [4:0]  odst [2];
  logic [15:0] scnt [2];

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t mq [2][$];
  int   mcnt [2] = '{0, 0};

  always #5 clk = ~clk;

  wb_pipe_stage #(.SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_pc(in_pc), .in_result(in_result), .in_wb_en(in_wb_en),
    .in_mem_read(in_mem_read), .in_dest(in_dest), .out_valid(ov[0]),
    .out_ready(out_ready), .out_pc(opc[0]), .out_result(ores[0]),
    .out_wb_en(owb[0]), .out_mem_read(omr[0]), .out_dest(odst[0]),
    .clr_cnt(clr_cnt), .stall_cnt(scnt[0])
  );

  wb_pipe_stage #(.SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_pc(in_pc), .in_result(in_result), .in_wb_en(in_wb_en),
    .in_mem_read(in_mem_read), .in_dest(in_dest), .out_valid(ov[1]),
    .out_ready(out_ready), .out_pc(opc[1]), .out_result(ores[1]),
    .out_wb_en(owb[1]), .out_mem_read(omr[1]), .out_dest(odst[1]),
    .clr_cnt(clr_cnt), .stall_cnt(scnt[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: k=0 holds at most one entry and can accept while draining;
  // k=1 holds up to two and accepts whenever fewer than two are held.
  function automatic bit m_ready(input int k);
    if (k == 1) return mq[1].size() < 2;
    return (mq[0].size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit   acc;
        bit   drn;
        ent_t e;
        acc = in_valid && m_ready(k);
        drn = (mq[k].size() > 0) && out_ready;
        if (clr_cnt) mcnt[k] = 0;
        else if ((mq[k].size() > 0) && !out_ready && mcnt[k] < 65535) mcnt[k]++;
        if (flush) begin
          mq[k].delete();
        end else begin
          if (drn) void'(mq[k].pop_front());
          if (acc) begin
            e = '{pc: in_pc, res: in_result, wb: in_wb_en, mr: in_mem_read, dest: in_dest};
            mq[k].push_back(e);
          end
        end
      end
    end
  end

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_ready[%0d]", k), 64'(rdy[k]), 64'(m_ready(k)));
        chk($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(mq[k].size() > 0));
        chk($sformatf("stall_cnt[%0d]", k), 64'(scnt[k]), 64'(mcnt[k]));
        if (mq[k].size() > 0) begin
          chk($sformatf("out_pc[%0d]", k), 64'(opc[k]), 64'(mq[k][0].pc));
          chk($sformatf("out_result[%0d]", k), 64'(ores[k]), 64'(mq[k][0].res));
          chk($sformatf("out_dest[%0d]", k), 64'(odst[k]), 64'(mq[k][0].dest));
          chk($sformatf("out_wb_en[%0d]", k), 64'(owb[k]), 64'(mq[k][0].wb));
          chk($sformatf("out_mem_read[%0d]", k), 64'(omr[k]), 64'(mq[k][0].mr));
        end else begin
          chk($sformatf("bubble_wb_en[%0d]", k), 64'(owb[k]), 64'd0);
          chk($sformatf("bubble_mem_read[%0d]", k), 64'(omr[k]), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] res,
                       input logic wb, input logic mr, input logic [4:0] dest);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_result   = res;
    in_wb_en    = wb;
    in_mem_read = mr;
    in_dest     = dest;
  endtask

  initial begin
    // Reset state
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", 64'(rdy[k]), 64'd1);
      chk("rst_out_valid", 64'(ov[k]), 64'd0);
      chk("rst_stall_cnt", 64'(scnt[k]), 64'd0);
      chk("rst_out_pc", 64'(opc[k]), 64'd0);
    end
    tick(); tick();
    rst = 1'b0;

    // Single entry
    out_ready = 1'b1;
    drive(32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd5);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("single_valid", 64'(ov[k]), 64'd1);
      chk("single_pc", 64'(opc[k]), 64'h40);
      chk("single_result", 64'(ores[k]), 64'hDEAD_BEEF);
      chk("single_dest", 64'(odst[k]), 64'd5);
      chk("single_wb_en", 64'(owb[k]), 64'd1);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("single_after_valid", 64'(ov[k]), 64'd0);
      chk("single_after_wb_en", 64'(owb[k]), 64'd0);
    end

    // Back-pressure: A then B with out_ready low
    out_ready = 1'b0;
    drive(32'h10, 32'h1111, 1'b1, 1'b0, 5'd1);
    tick();
    drive(32'h14, 32'h2222, 1'b1, 1'b1, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready_skid", 64'(rdy[1]), 64'd0);
    chk("bp_hold_pc_skid", 64'(opc[1]), 64'h10);
    tick(); tick();
    chk("bp_stall_cnt_skid", 64'(scnt[1]), 64'd3);
    chk("bp_hold_pc_still", 64'(opc[1]), 64'h10);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_b_pc", 64'(opc[1]), 64'h14);
    chk("bp_in_ready_back", 64'(rdy[1]), 64'd1);
    tick();
    chk("bp_empty", 64'(ov[1]), 64'd0);

    // Streaming throughput
    for (int i = 0; i < 8; i++) begin
      drive(32'h100 + 32'(4 * i), 32'(i * 3 + 7), 1'b1, i[0], 5'(i));
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("stream_valid", 64'(ov[k]), 64'd1);
        chk("stream_pc", 64'(opc[k]), 64'h100 + 64'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();

    // Flush while holding entries
    out_ready = 1'b0;
    drive(32'h300, 32'h3333, 1'b1, 1'b1, 5'd3);
    tick();
    drive(32'h304, 32'h4444, 1'b1, 1'b1, 5'd4);
    tick();
    chk("flush_pre_full", 64'(rdy[1]), 64'd0);
    drive(32'h200, 32'h5555, 1'b1, 1'b1, 5'd6);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("flush_valid", 64'(ov[k]), 64'd0);
      chk("flush_wb_en", 64'(owb[k]), 64'd0);
      chk("flush_mem_read", 64'(omr[k]), 64'd0);
    end
    out_ready = 1'b1;
    tick(); tick();

    // Stall counter saturation and clear
    clr_cnt = 1'b1;
    tick();
    clr_cnt   = 1'b0;
    out_ready = 1'b0;
    drive(32'h500, 32'h6666, 1'b0, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    for (int k = 0; k < 2; k++) chk("cnt_saturated", 64'(scnt[k]), 64'hFFFF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int k = 0; k < 2; k++) chk("cnt_cleared", 64'(scnt[k]), 64'd0);
    tick();
    for (int k = 0; k < 2; k++) chk("cnt_restart", 64'(scnt[k]), 64'd1);

    // Asynchronous reset while the skid instance is full
    drive(32'h504, 32'h7777, 1'b1, 1'b0, 5'd8);
    tick();
    in_valid = 1'b0;
    chk("arst_pre_full", 64'(rdy[1]), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_valid", 64'(ov[k]), 64'd0);
      chk("arst_stall_cnt", 64'(scnt[k]), 64'd0);
      chk("arst_in_ready", 64'(rdy[k]), 64'd1);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
